// File: rtl/bcd_para_binario.sv
// bcd_para_binario: three-digit BCD to 10-bit binary converter.
// Reverse double-dabble, one shift/correct step per clock, start/busy/done handshake.
module bcd_para_binario (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] centena,
  input  logic [3:0] dezena,
  input  logic [3:0] unidade,
  output logic [9:0] binario,
  output logic       ocupado,
  output logic       pronto,
  output logic       erro
);

  typedef enum logic {
    OCIOSO,
    CONVERTE
  } estado_t;

  estado_t     estado, estado_prox;
  logic [21:0] trab, trab_prox;
  logic [21:0] desloc, corrigido;
  logic [3:0]  cont, cont_prox;
  logic [9:0]  binario_prox;
  logic        pronto_prox;
  logic        erro_prox;
  logic        invalido;

  function automatic logic [3:0] ajusta(input logic [3:0] n);
    return (n >= 4'd8) ? n - 4'd3 : n;
  endfunction

  // One reverse double-dabble step on the working register.
  always_comb begin
    desloc    = {1'b0, trab[21:1]};
    corrigido = {ajusta(desloc[21:18]),
                 ajusta(desloc[17:14]),
                 ajusta(desloc[13:10]),
                 desloc[9:0]};
  end

  assign invalido = (centena > 4'd9) |
                    (dezena  > 4'd9) |
                    (unidade > 4'd9);

  assign ocupado = (estado == CONVERTE);

  // Next-state and next-output logic; a held bad request pulses
  // pronto on alternate cycles so it never stays high twice in a row.
  always_comb begin
    estado_prox  = estado;
    trab_prox    = trab;
    cont_prox    = cont;
    binario_prox = binario;
    pronto_prox  = 1'b0;
    erro_prox    = erro;
    unique case (estado)
      OCIOSO: begin
        if (iniciar) begin
          if (invalido) begin
            if (!pronto) begin
              erro_prox   = 1'b1;
              pronto_prox = 1'b1;
            end
          end else begin
            trab_prox   = {centena, dezena, unidade, 10'b0};
            cont_prox   = 4'd0;
            erro_prox   = 1'b0;
            estado_prox = CONVERTE;
          end
        end
      end
      CONVERTE: begin
        trab_prox = corrigido;
        cont_prox = cont + 4'd1;
        if (cont == 4'd9) begin
          binario_prox = corrigido[9:0];
          pronto_prox  = 1'b1;
          estado_prox  = OCIOSO;
        end
      end
      default: estado_prox = OCIOSO;
    endcase
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado  <= OCIOSO;
      trab    <= '0;
      cont    <= '0;
      binario <= '0;
      pronto  <= 1'b0;
      erro    <= 1'b0;
    end else begin
      estado  <= estado_prox;
      trab    <= trab_prox;
      cont    <= cont_prox;
      binario <= binario_prox;
      pronto  <= pronto_prox;
      erro    <= erro_prox;
    end
  end

endmodule

// File: tb/tb_bcd_para_binario.sv
// tb_bcd_para_binario: directed bench for bcd_para_binario.
// Arithmetic reference model checked every cycle plus literal expectations.
module tb_bcd_para_binario;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic [3:0] centena = '0;
  logic [3:0] dezena = '0;
  logic [3:0] unidade = '0;
  logic [9:0] binario;
  logic       ocupado;
  logic       pronto;
  logic       erro;

  int total = 0;
  int bad = 0;
  bit chk_on = 0;

  int m_left = 0;
  int m_val = 0;
  int m_bin = 0;
  bit m_err = 0;
  bit m_pr = 0;

  always #5 clock = ~clock;

  bcd_para_binario dut (
    .clock(clock),
    .reset(reset),
    .iniciar(iniciar),
    .centena(centena),
    .dezena(dezena),
    .unidade(unidade),
    .binario(binario),
    .ocupado(ocupado),
    .pronto(pronto),
    .erro(erro)
  );

  task automatic chk(input string nome,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nome, act, exp);
    end
  endtask

  // Reference: value = 100c+10d+u, delivered ten cycles after accept.
  always @(posedge clock) begin : modelo
    bit np;
    np = 0;
    if (reset) begin
      m_left = 0;
      m_bin = 0;
      m_err = 0;
      m_pr = 0;
    end else begin
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_bin = m_val;
          np = 1;
        end
      end else if (iniciar) begin
        if (centena <= 9 && dezena <= 9 && unidade <= 9) begin
          m_val = centena * 100 + dezena * 10 + unidade;
          m_left = 10;
          m_err = 0;
        end else if (!m_pr) begin
          m_err = 1;
          np = 1;
        end
      end
      m_pr = np;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (chk_on)
      chk("ciclo", {19'b0, ocupado, pronto, erro, binario},
          {19'b0, (m_left > 0), m_pr, m_err, m_bin[9:0]});
  end

  task automatic pede(input logic [3:0] c,
                      input logic [3:0] d,
                      input logic [3:0] u);
    @(negedge clock);
    centena = c;
    dezena = d;
    unidade = u;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
  endtask

  task automatic espera(output int n, output int oc);
    n = 0;
    oc = 0;
    while (pronto !== 1'b1 && n < 40) begin
      if (ocupado === 1'b1) oc++;
      @(negedge clock);
      n++;
    end
    if (n >= 40) chk("timeout_pronto", 0, 1);
  endtask

  initial begin
    int n, oc, cnt;
    repeat (2) @(negedge clock);
    chk("reset_saidas", {ocupado, pronto, erro, binario}, 0);
    reset = 1'b0;
    chk_on = 1;

    pede(4'd9, 4'd9, 4'd9);
    espera(n, oc);
    chk("999_ocupado", oc, 10);
    chk("999_latencia", n, 10);
    chk("999_valor", binario, 999);
    chk("999_erro", erro, 0);

    pede(4'd0, 4'd0, 4'd0);
    espera(n, oc);
    chk("000_latencia", n, 10);
    chk("000_valor", binario, 0);

    @(negedge clock);
    centena = 4'd2;
    dezena = 4'd5;
    unidade = 4'd5;
    iniciar = 1'b1;
    @(negedge clock);
    espera(n, oc);
    chk("255_valor", binario, 255);
    centena = 4'd1;
    dezena = 4'd2;
    unidade = 4'd8;
    @(negedge clock);
    iniciar = 1'b0;
    chk("128_aceito", ocupado, 1);
    espera(n, oc);
    chk("b2b_intervalo", n + 1, 11);
    chk("128_valor", binario, 128);

    pede(4'd2, 4'd5, 4'd5);
    espera(n, oc);
    repeat (2) @(negedge clock);
    pede(4'd3, 4'hA, 4'd1);
    chk("inv_pronto", pronto, 1);
    chk("inv_erro", erro, 1);
    chk("inv_ocupado", ocupado, 0);
    chk("inv_binario", binario, 255);
    @(negedge clock);
    chk("inv_pronto_cai", pronto, 0);

    pede(4'd7, 4'd4, 4'd2);
    centena = 4'd0;
    dezena = 4'd0;
    unidade = 4'd1;
    iniciar = 1'b1;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (i == 3) iniciar = 1'b0;
      if (pronto === 1'b1) cnt++;
      @(negedge clock);
    end
    chk("742_pulsos", cnt, 1);
    chk("742_valor", binario, 742);
    chk("742_erro", erro, 0);

    pede(4'd5, 4'd0, 4'd0);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_meio", {ocupado, pronto, erro, binario}, 0);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (pronto === 1'b1) cnt++;
      @(negedge clock);
    end
    chk("rst_sem_pronto", cnt, 0);
    pede(4'd0, 4'd4, 4'd2);
    espera(n, oc);
    chk("042_valor", binario, 42);

    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_para_binario.md
# bcd_para_binario

Sequential three-digit BCD-to-binary converter using the reverse double-dabble algorithm: shift right one bit per clock, then subtract 3 from each BCD nibble that is ≥ 8. It converts BCD digits (keypad entry, display-edit paths) back into a 10-bit binary value for the datapath. It is the inverse of the binary-to-BCD display path. It uses a start/busy/done handshake and holds its result until the next accepted request.

## Interface
- Parameters: none. The width is fixed at 3 digits in and 10 bits out, because 999 < 1024.
- clock  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- iniciar  input  1  start request; sampled only in OCIOSO
- centena  input  4  hundreds digit, BCD 0–9
- dezena  input  4  tens digit, BCD 0–9
- unidade  input  4  units digit, BCD 0–9
- binario  output  10  converted value, registered; held between conversions
- ocupado  output  1  high while in CONVERTE
- pronto  output  1  one-cycle pulse when a request completes (result or error)
- erro  output  1  registered; high if the last accepted request had a digit > 9

## Operation
- Internal working register is 22 bits: {centena, dezena, unidade, 10-bit binary field}, plus a 4-bit iteration counter.
- FSM states: OCIOSO, CONVERTE.
- OCIOSO with iniciar = 1 and all digits ≤ 9:
  - load the working register as {centena, dezena, unidade, 10'b0} and set counter = 0
  - set erro = 0 and go to CONVERTE
- OCIOSO with iniciar = 1 and any digit > 9:
  - stay in OCIOSO; set erro = 1 and pulse pronto next cycle
  - binario is unchanged
- CONVERTE, each cycle:
  - logical right shift of the whole 22-bit register by 1
  - then, for each of the three shifted nibbles independently, if the nibble is ≥ 8, subtract 3
  - counter increments
- When the 10th iteration completes (counter was 9):
  - binario takes the low 10 bits of the post-correction register
  - pronto = 1 for that cycle; return to OCIOSO
- iniciar is ignored while in CONVERTE. Inputs are captured only at the accept edge; changes afterwards have no effect.
- All arithmetic is unsigned. The BCD nibbles are all zero after the 10th iteration; no overflow is possible for valid input.
- Reset is synchronous and wins over everything, including mid-conversion: the state returns to OCIOSO and the partial result is discarded.

## Timing
- Reset values: binario = 0, ocupado = 0, pronto = 0, erro = 0, state OCIOSO, counter = 0.
- Valid request, with iniciar sampled high at edge E0:
  - ocupado is high from after E0 to E10
  - iterations occur at E1..E10
  - binario is updated and pronto is high in the cycle after E10, i.e. 10 cycles of latency
- Invalid request sampled at E0: erro and pronto are high after E0; pronto drops after E1; ocupado stays 0.
- Back-to-back: in the cycle pronto is high, the FSM is already in OCIOSO, so an iniciar held high is accepted at the next edge. Steady-state throughput is one conversion per 11 cycles.
- binario and erro are stable between pronto pulses.
- pronto never asserts for two consecutive cycles, and never asserts together with ocupado.

## Test plan
- Digits 9,9,9, iniciar for 1 cycle:
  - ocupado is high for 10 cycles
  - then pronto pulses with binario = 999 (10'b1111100111) and erro = 0
- Digits 0,0,0: after 10 cycles binario = 0 and pronto pulses.
- Digits 2,5,5 then 1,2,8 with iniciar held high continuously:
  - binario = 255, then 128, on two pronto pulses 11 cycles apart
- Digits 3,A,1 after a prior result of 255:
  - erro = 1 and pronto pulses one cycle after the request
  - binario stays 255; ocupado is never asserted
- Start 7,4,2, then change the inputs to 0,0,1 and pulse iniciar during CONVERTE:
  - the result is 742 and only one pronto occurs
- Start 5,0,0 and assert reset at iteration 5:
  - all outputs are 0 the next cycle and no pronto occurs
  - a following request for 0,4,2 yields 42
